// File: rtl/tpu_dma_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : tpu_dma_pkg                                                 |
// | Description: Shared opcodes, state encoding and command-word layout for  |
// |              the host-side DMA burst controller.                         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package tpu_dma_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LD_W   = 4'h1;
  localparam logic [3:0] OP_LD_INP = 4'h2;
  localparam logic [3:0] OP_LD_INS = 4'h3;
  localparam logic [3:0] OP_START  = 4'h4;
  localparam logic [3:0] OP_CLR    = 4'hF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } dma_state_e;

  // Command word layout at default widths (CMD_W=16, LEN_W=6, ADDR_W=6).
  typedef struct packed {
    logic [3:0] op;
    logic [5:0] len;
    logic [5:0] addr;
  } dma_cmd_t;

endpackage : tpu_dma_pkg
`default_nettype wire

// File: rtl/dma_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : dma_burst_ctrl                                              |
// | Description: Decodes host command words and steers load bursts into one  |
// |              of NUM_TGT on-chip buffers; pulses start and tracks a       |
// |              sticky illegal-opcode error.                                |
// | Ports      : clk, reset (async, active-low)                              |
// |              uio_in/in_valid/in_ready - inbound word handshake           |
// |              wr_en/wr_addr/wr_data    - buffer write port (registered)   |
// |              start, busy, err, beats_left - control and status           |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module dma_burst_ctrl
  import tpu_dma_pkg::*;
#(
  parameter int CMD_W    = 16,
  parameter int ADDR_W   = 6,
  parameter int LEN_W    = 6,
  parameter int NUM_TGT  = 3,
  parameter int START_OP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CMD_W-1:0]   uio_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NUM_TGT-1:0] wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [CMD_W-1:0]   wr_data,
  output logic               start,
  output logic               busy,
  output logic               err,
  output logic [LEN_W-1:0]   beats_left
);

  localparam int TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  localparam logic [0:0] c_st_idle = IDLE;
  localparam logic [0:0] c_st_load = LOAD;

  localparam logic [2:0] c_dec_nop   = 3'd0;
  localparam logic [2:0] c_dec_load  = 3'd1;
  localparam logic [2:0] c_dec_start = 3'd2;
  localparam logic [2:0] c_dec_clr   = 3'd3;
  localparam logic [2:0] c_dec_ill   = 3'd4;

  if ((4 + LEN_W + ADDR_W > CMD_W) || (NUM_TGT < 1) ||
      (START_OP <= NUM_TGT) || (START_OP >= 15)) begin : g_param_check
    $error("dma_burst_ctrl: illegal parameter combination");
  end

  function automatic logic [2:0] decode_op(input logic [3:0] op);
    int unsigned v;
    v = int'(op);
    if (op == OP_NOP)                        return c_dec_nop;
    else if (v >= 1 && v <= NUM_TGT)        return c_dec_load;
    else if (v == START_OP)                  return c_dec_start;
    else if (op == OP_CLR)                   return c_dec_clr;
    else                                     return c_dec_ill;
  endfunction

  logic [0:0]        r_state;
  logic [TGT_W-1:0]  r_tgt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;

  logic              w_xfer;
  logic [3:0]        w_op;
  logic [2:0]        w_dec;

  assign in_ready = (r_state == c_st_idle) || (r_state == c_st_load);
  assign w_xfer   = in_valid & in_ready;
  assign w_op     = uio_in[CMD_W-1:CMD_W-4];
  assign w_dec    = decode_op(w_op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_st_idle;
      r_tgt      <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      wr_en      <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      beats_left <= '0;
    end else begin
      // Strobes are single-cycle; address/data hold their last value.
      wr_en <= '0;
      start <= 1'b0;
      if (w_xfer) begin
        if (r_state == c_st_load) begin
          // Inside a burst every word is data, whatever its top bits say.
          wr_en      <= NUM_TGT'(1) << r_tgt;
          wr_addr    <= r_addr;
          wr_data    <= uio_in;
          beats_left <= r_cnt;
          r_addr     <= ADDR_W'(r_addr + 1'b1);
          r_cnt      <= LEN_W'(r_cnt - 1'b1);
          if (r_cnt == '0) begin
            r_state <= c_st_idle;
            busy    <= 1'b0;
          end
        end else begin
          case (w_dec)
            c_dec_load: begin
              r_tgt   <= TGT_W'(w_op - 4'd1);
              r_addr  <= uio_in[ADDR_W-1:0];
              r_cnt   <= uio_in[ADDR_W+LEN_W-1:ADDR_W];
              r_state <= c_st_load;
              busy    <= 1'b1;
            end
            c_dec_start: start <= 1'b1;
            c_dec_clr:   err   <= 1'b0;
            c_dec_ill:   err   <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule : dma_burst_ctrl
`default_nettype wire

// File: tb/tb_dma_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_dma_burst_ctrl                                           |
// | Description: Self-checking bench for dma_burst_ctrl: directed scenarios  |
// |              followed by a random word stream, every cycle compared      |
// |              against a burst-level reference model.                      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_dma_burst_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] uio_in;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        busy;
  logic        err;
  logic [5:0]  beats_left;

  dma_burst_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .uio_in     (uio_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .busy       (busy),
    .err        (err),
    .beats_left (beats_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: tracks the burst as "beats still to come" and the next
  // buffer address, working from the command semantics rather than a cnt.
  bit m_in_burst;
  int m_tgt;
  int m_next_addr;
  int m_remaining;
  bit m_err;

  task automatic model_reset();
    m_in_burst  = 0;
    m_tgt       = 0;
    m_next_addr = 0;
    m_remaining = 0;
    m_err       = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wr_en"},      32'(wr_en),      32'd0);
    check({tag, ".wr_addr"},    32'(wr_addr),    32'd0);
    check({tag, ".wr_data"},    32'(wr_data),    32'd0);
    check({tag, ".start"},      32'(start),      32'd0);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".err"},        32'(err),        32'd0);
    check({tag, ".beats_left"}, 32'(beats_left), 32'd0);
  endtask

  // One clock: present word at negedge, evaluate model at posedge, compare
  // just after the edge, return at the next negedge.
  task automatic step(input logic v, input logic [15:0] w);
    int exp_en, exp_addr, exp_data, exp_bl, op;
    bit exp_start;
    in_valid = v;
    uio_in   = w;
    @(posedge clk);
    exp_en = 0; exp_addr = 0; exp_data = 0; exp_bl = 0; exp_start = 0;
    if (v) begin
      if (m_in_burst) begin
        exp_en      = 1 << m_tgt;
        exp_addr    = m_next_addr;
        exp_data    = int'(w);
        exp_bl      = m_remaining - 1;
        m_next_addr = (m_next_addr + 1) % 64;
        m_remaining = m_remaining - 1;
        if (m_remaining == 0) m_in_burst = 0;
      end else begin
        op = int'(w[15:12]);
        if (op == 0) begin
        end else if (op >= 1 && op <= 3) begin
          m_in_burst  = 1;
          m_tgt       = op - 1;
          m_next_addr = int'(w[5:0]);
          m_remaining = int'(w[11:6]) + 1;
        end else if (op == 4) begin
          exp_start = 1;
        end else if (op == 15) begin
          m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end
    #1;
    check("wr_en", 32'(wr_en), 32'(exp_en));
    if (exp_en != 0) begin
      check("wr_addr",    32'(wr_addr),    32'(exp_addr));
      check("wr_data",    32'(wr_data),    32'(exp_data));
      check("beats_left", 32'(beats_left), 32'(exp_bl));
    end
    check("start",    32'(start),    32'(exp_start));
    check("busy",     32'(busy),     32'(m_in_burst));
    check("err",      32'(err),      32'(m_err));
    check("in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  initial begin
    logic [15:0] w;
    int          sel;
    in_valid = 1'b0;
    uio_in   = 16'h0000;
    reset    = 1'b0;
    model_reset();

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset.in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    idle(1);

    // Weight burst: 9 beats from address 3, no gaps.
    step(1'b1, 16'h1203);
    for (int i = 0; i < 9; i++) step(1'b1, 16'hA000 + 16'(i));
    idle(2);

    // Input burst wrapping 62,63,0 with two idle cycles between beats.
    step(1'b1, 16'h20BE);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'hB100 + 16'(i));
      if (i < 2) idle(2);
    end
    idle(1);

    // Start word inside a burst is data; right after the burst it is a start.
    step(1'b1, 16'h3000);
    step(1'b1, 16'h4444);
    step(1'b1, 16'h4000);
    idle(2);

    // Error is sticky but does not block decoding; 0xF clears it.
    step(1'b1, 16'h9000);
    idle(1);
    step(1'b1, 16'h4000);
    step(1'b1, 16'hF000);
    idle(1);

    // Asynchronous reset in the middle of a 17-beat burst.
    step(1'b1, 16'h1405);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hC000 + 16'(i));
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 16'h4000);
    idle(1);

    // Random stream: mixed commands, data and stalls.
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: w = {4'($urandom_range(1, 3)), 6'($urandom_range(0, 5)), 6'($urandom)};
        3:       w = {4'h1, 6'($urandom_range(40, 63)), 6'($urandom)};
        4:       w = 16'h4000 | 16'($urandom_range(0, 4095));
        5:       w = 16'hF000;
        6:       w = {4'($urandom_range(5, 14)), 12'($urandom)};
        default: w = 16'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, w);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dma_burst_ctrl
`default_nettype wire
